// File: rtl/aximm_patgen_mc.sv
`default_nettype none
// ============================================================================
// Module   : aximm_patgen_mc
// Purpose  : Multi-channel AXI-MM traffic pattern generator. Builds fixed,
//            LFSR, incrementing or walking-ones beats, buffers them in an
//            internal sync FIFO, presents them on a valid/ready stream and
//            mirrors every generated beat on an expected-data port for the
//            downstream checker.
// Ports    : wr_clk, rst_n (async, active low)
//            patgen_en / patgen_sel / patgen_cnt / cntuspatt_en : burst control
//            chkr_fifo_full      : checker backpressure, stalls generation
//            patgen_dout / axist_valid / axist_rdy : output stream
//            patgen_exp_dout / patgen_data_wr      : expected beat + strobe
//            patgen_busy / patgen_done             : status
//            stall_cnt           : valid && !rdy cycle counter
// Options  : `AXIMM_PATGEN_STALL_CNT_EN enables the stall counter; when it is
//            undefined stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module aximm_patgen_mc #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CHNL   = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           wr_clk,
  input  logic                           rst_n,
  input  logic                           patgen_en,
  input  logic [1:0]                     patgen_sel,
  input  logic [CNT_WIDTH-1:0]           patgen_cnt,
  input  logic                           cntuspatt_en,
  input  logic                           chkr_fifo_full,
  output logic [NUM_CHNL*DATA_WIDTH-1:0] patgen_dout,
  output logic                           axist_valid,
  input  logic                           axist_rdy,
  output logic [NUM_CHNL*DATA_WIDTH-1:0] patgen_exp_dout,
  output logic                           patgen_data_wr,
  output logic                           patgen_busy,
  output logic                           patgen_done,
  output logic [15:0]                    stall_cnt
);

  localparam int          C_W          = NUM_CHNL * DATA_WIDTH;
  localparam int          C_AW         = $clog2(FIFO_DEPTH);
  localparam int          C_IW         = $clog2(DATA_WIDTH);
  localparam int          C_REP        = DATA_WIDTH / 32;
  localparam logic [31:0] C_LFSR_SEED  = 32'hACE1_9001;
  localparam logic [31:0] C_INCR_SEED  = 32'h4444_4444;
  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] C_LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] C_FIXED_WORD = 32'h3333_3333;
  localparam logic [C_AW:0]     C_DEPTH_CNT = (C_AW+1)'(FIFO_DEPTH);
  localparam logic [C_IW-1:0]   C_IDX_LAST  = C_IW'(DATA_WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_en_d;
  logic [1:0]            r_sel;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_cont;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  logic [31:0]           r_lfsr;
  logic [31:0]           r_incr;
  logic [C_IW-1:0]       r_idx;

  logic [C_W-1:0]        r_mem [FIFO_DEPTH];
  logic [C_AW-1:0]       r_wr_ptr;
  logic [C_AW-1:0]       r_rd_ptr;
  logic [C_AW:0]         r_count;
  logic                  r_valid;
  logic [C_W-1:0]        r_dout;

  logic                  w_start;
  logic                  w_gen_stop;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;
  logic [31:0]           w_lfsr_nxt;
  logic [DATA_WIDTH-1:0] w_base;
  logic [C_W-1:0]        w_beat;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign w_start    = (r_state == S_IDLE) && patgen_en && !r_en_d;
  // Abort or end of continuous mode stops generation in the same cycle
  assign w_gen_stop = !patgen_en || (r_cont && !cntuspatt_en);
  // Occupancy is checked before any same-cycle pop, so the FIFO cannot overflow
  assign w_push     = (r_state == S_GEN) && !w_gen_stop &&
                      (r_count < C_DEPTH_CNT) && !chkr_fifo_full;
  assign w_last     = w_push && !r_cont &&
                      ((r_beat_cnt + CNT_WIDTH'(1)) == r_cnt);
  assign w_pop      = (!r_valid || axist_rdy) && (r_count != '0);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_en_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= patgen_en;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if ((patgen_cnt == '0) && !cntuspatt_en) w_state_nxt = S_DONE;
          else                                      w_state_nxt = S_GEN;
        end
      end
      S_GEN: begin
        if (w_gen_stop || w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_count == '0) && !r_valid) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst parameters and pattern state (pattern state survives across bursts)
  // --------------------------------------------------------------------------
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? C_LFSR_MASK : 32'h0);

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 2'b00;
      r_cnt      <= '0;
      r_cont     <= 1'b0;
      r_beat_cnt <= '0;
      r_lfsr     <= C_LFSR_SEED;
      r_incr     <= C_INCR_SEED;
      r_idx      <= '0;
    end else begin
      if (w_start) begin
        r_sel      <= patgen_sel;
        r_cnt      <= patgen_cnt;
        r_cont     <= cntuspatt_en;
        r_beat_cnt <= '0;
      end else if (w_push) begin
        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      end
      if (w_push) begin
        case (r_sel)
          2'b01:   r_lfsr <= w_lfsr_nxt;
          2'b10:   r_incr <= r_incr + 32'd1;
          2'b11:   r_idx  <= (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IW'(1);
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Beat construction: base word, then per-lane byte rotation
  // --------------------------------------------------------------------------
  always_comb begin
    w_base = '0;
    case (r_sel)
      2'b00:   w_base = {C_REP{C_FIXED_WORD}};
      2'b01:   w_base = {C_REP{r_lfsr}};
      2'b10:   w_base = {C_REP{r_incr}};
      default: w_base[r_idx] = 1'b1;
    endcase
  end

  for (genvar c = 0; c < NUM_CHNL; c++) begin : g_lane
    localparam int ROT = (8 * c) % DATA_WIDTH;
    if (ROT == 0) begin : g_rot0
      assign w_beat[c*DATA_WIDTH +: DATA_WIDTH] = w_base;
    end else begin : g_rot
      assign w_beat[c*DATA_WIDTH +: DATA_WIDTH] =
        {w_base[DATA_WIDTH-ROT-1:0], w_base[DATA_WIDTH-1:DATA_WIDTH-ROT]};
    end
  end

  // --------------------------------------------------------------------------
  // Sync FIFO; storage needs no reset since occupancy is tracked separately
  // --------------------------------------------------------------------------
  always_ff @(posedge wr_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_beat;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (C_AW+1)'(1);
        2'b01:   r_count <= r_count - (C_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Output head register: always one cycle behind the FIFO, data zeroed when idle
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_dout  <= r_mem[r_rd_ptr];
    end else if (axist_rdy) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Optional stall counter
  // --------------------------------------------------------------------------
`ifdef AXIMM_PATGEN_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0;
    end else if (w_start && (w_state_nxt == S_GEN)) begin
      r_stall_cnt <= 16'h0;
    end else if (r_valid && !axist_rdy && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign patgen_dout     = r_dout;
  assign axist_valid     = r_valid;
  assign patgen_data_wr  = w_push;
  assign patgen_exp_dout = w_push ? w_beat : '0;
  assign patgen_busy     = (r_state != S_IDLE);
  assign patgen_done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_aximm_patgen_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_aximm_patgen_mc
// Purpose  : Self-checking bench for aximm_patgen_mc (two 64-bit lanes).
//            A behavioural pattern model predicts every generated beat; a
//            queue scoreboard predicts the stream output order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aximm_patgen_mc;
  localparam int DW = 64, NC = 2, W = DW * NC, DEPTH = 16, CW = 8, REP = DW / 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [CW-1:0] cnt = '0;
  logic          cont = 1'b0, full = 1'b0, rdy = 1'b0;
  logic [W-1:0]  dout, exp_dout;
  logic          valid, data_wr, busy, done;
  logic [15:0]   stall;

  aximm_patgen_mc #(.DATA_WIDTH(DW), .NUM_CHNL(NC), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .wr_clk(clk), .rst_n(rst_n), .patgen_en(en), .patgen_sel(sel), .patgen_cnt(cnt),
    .cntuspatt_en(cont), .chkr_fifo_full(full), .patgen_dout(dout), .axist_valid(valid),
    .axist_rdy(rdy), .patgen_exp_dout(exp_dout), .patgen_data_wr(data_wr),
    .patgen_busy(busy), .patgen_done(done), .stall_cnt(stall));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Behavioural model state
  logic [31:0]  m_lfsr, m_incr;
  int           m_idx;
  logic [1:0]   m_sel;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] strobe_log[$];
  logic [W-1:0] xfer_log[$];
  int           n_strobe, n_xfer, n_done;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] lanes(input logic [DW-1:0] b);
    logic [W-1:0] r;
    int rot;
    for (int c = 0; c < NC; c++) begin
      rot = (8 * c) % DW;
      r[c*DW +: DW] = (rot == 0) ? b : ((b << rot) | (b >> (DW - rot)));
    end
    return r;
  endfunction

  task automatic model_reset();
    m_lfsr = 32'hACE1_9001;
    m_incr = 32'h4444_4444;
    m_idx  = 0;
    exp_q.delete();
  endtask

  task automatic model_beat(output logic [W-1:0] r);
    logic [DW-1:0] b;
    logic [31:0]   mask;
    int            taps[4];
    taps = '{32, 22, 2, 1};
    mask = 32'h0;
    case (m_sel)
      2'd0: b = {REP{32'h3333_3333}};
      2'd1: begin
        b = {REP{m_lfsr}};
        foreach (taps[k]) mask = mask | (32'h1 << (taps[k] - 1));
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? mask : 32'h0);
      end
      2'd2: begin
        b = {REP{m_incr}};
        m_incr = m_incr + 32'd1;
      end
      default: begin
        b = DW'(1) << m_idx;
        m_idx = (m_idx + 1) % DW;
      end
    endcase
    r = lanes(b);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en && rst_n) begin
      if (data_wr) begin
        model_beat(e);
        check("exp_dout", exp_dout, e);
        check("strobe_while_full", W'(full), W'(0));
        check("strobe_busy", W'(busy), W'(1));
        exp_q.push_back(e);
        strobe_log.push_back(exp_dout);
        n_strobe++;
      end
      if (valid && rdy) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_xfer actual=%h required=<none>", dout);
        end else begin
          check("dout", dout, exp_q.pop_front());
        end
        xfer_log.push_back(dout);
        n_xfer++;
      end
      if (!valid) check("dout_zero_when_invalid", dout, '0);
      if (done) n_done++;
    end
  end

  task automatic reset_counters();
    n_strobe = 0; n_xfer = 0; n_done = 0;
    strobe_log.delete(); xfer_log.delete();
  endtask

  task automatic start(input logic [1:0] s, input logic [CW-1:0] c, input logic ct);
    @(posedge clk); #1;
    sel = s; cnt = c; cont = ct; m_sel = s; en = 1'b1;
  endtask

  task automatic run_until_done(input int rdy_pct, input int full_pct, input int budget, input string name);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      @(posedge clk); #1;
      rdy  = ($urandom_range(0, 99) < rdy_pct);
      full = ($urandom_range(0, 99) < full_pct);
      @(negedge clk); #1;
    end
    if (n_done == 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    @(posedge clk); #1;
    en = 1'b0; cont = 1'b0; full = 1'b0;
    @(negedge clk); #1;
    check({name, "_busy_end"}, W'(busy), W'(0));
    check({name, "_done_pulses"}, W'(n_done), W'(1));
    check({name, "_scoreboard_empty"}, W'(exp_q.size()), W'(0));
  endtask

  typedef struct {
    logic [1:0]    sel;
    logic [CW-1:0] cnt;
    int            rdy_pct;
    int            full_pct;
    int            exp_beats;
  } vec_t;

  initial begin
    vec_t         tbl[8];
    logic [W-1:0] first;
    bit           found;

    tbl[0] = '{sel: 2'd2, cnt: 8'd0,   rdy_pct: 100, full_pct: 0,  exp_beats: 0};
    tbl[1] = '{sel: 2'd1, cnt: 8'd1,   rdy_pct: 100, full_pct: 0,  exp_beats: 1};
    tbl[2] = '{sel: 2'd3, cnt: 8'd255, rdy_pct: 90,  full_pct: 10, exp_beats: 255};
    for (int i = 3; i < 8; i++) begin
      tbl[i].sel       = 2'($urandom_range(0, 3));
      tbl[i].cnt       = CW'($urandom_range(2, 60));
      tbl[i].rdy_pct   = $urandom_range(20, 100);
      tbl[i].full_pct  = $urandom_range(0, 50);
      tbl[i].exp_beats = int'(tbl[i].cnt);
    end

    model_reset();
    reset_counters();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", W'(valid), W'(0));
    check("rst_dout", dout, '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_data_wr", W'(data_wr), W'(0));
    check("rst_exp_dout", exp_dout, '0);
    check("rst_stall", W'(stall), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Incrementing burst of 4 with ready held high
    reset_counters(); rdy = 1'b1;
    start(2'b10, 8'd4, 1'b0);
    run_until_done(100, 0, 200, "t1");
    check("t1_strobes", W'(n_strobe), W'(4));
    check("t1_xfers", W'(n_xfer), W'(4));
    check("t1_first_lane0", W'(xfer_log[0][63:0]), W'(64'h4444_4444_4444_4444));
    check("t1_last_lane0", W'(xfer_log[3][63:0]), W'(64'h4444_4447_4444_4447));
    check("t1_last_lane1", W'(xfer_log[3][127:64]), W'(64'h4444_4744_4444_4744));

    // Asynchronous reset in the middle of a burst
    reset_counters(); rdy = 1'b0;
    start(2'b01, 8'd20, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin @(negedge clk); found = valid; end
    check("t6_valid_before_reset", W'(found), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", W'(valid), W'(0));
    check("t6_async_busy", W'(busy), W'(0));
    check("t6_async_dout", dout, '0);
    en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_post_reset_valid", W'(valid), W'(0));
    end

    // LFSR burst, first beat held while ready is low for 10 cycles
    reset_counters(); rdy = 1'b0;
    start(2'b01, 8'd3, 1'b0);
    first = lanes({REP{32'hACE1_9001}});
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin @(negedge clk); found = valid; end
    check("t2_valid_seen", W'(found), W'(1));
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_dout", dout, first);
      check("t2_hold_valid", W'(valid), W'(1));
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    run_until_done(100, 0, 100, "t2");
    check("t2_strobes", W'(n_strobe), W'(3));
    check("t2_first_xfer", xfer_log[0], first);
`ifdef AXIMM_PATGEN_STALL_CNT_EN
    check("t2_stall_cnt", W'(stall), W'(10));
`else
    check("t2_stall_cnt", W'(stall), W'(0));
`endif

    // Walking ones, 70 beats: FIFO plus head register hold 17 with ready low
    reset_counters(); rdy = 1'b0;
    start(2'b11, 8'd70, 1'b0);
    repeat (40) @(negedge clk);
    #1;
    check("t3_strobes_stalled", W'(n_strobe), W'(17));
    run_until_done(70, 0, 1000, "t3");
    check("t3_strobes", W'(n_strobe), W'(70));
    check("t3_xfers", W'(n_xfer), W'(70));
    check("t3_beat0", W'(strobe_log[0][63:0]), W'(64'h1));
    check("t3_beat63", W'(strobe_log[63][63:0]), W'(64'h8000_0000_0000_0000));
    check("t3_beat64_wrap", W'(strobe_log[64][63:0]), W'(64'h1));

    // Continuous mode with toggling checker backpressure (count ignored)
    reset_counters(); rdy = 1'b1;
    start(2'b10, 8'd0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      full = ((i / 4) % 2 == 1);
    end
    @(posedge clk); #1;
    cont = 1'b0; full = 1'b0;
    run_until_done(100, 0, 100, "t4");
    check("t4_enough_strobes", W'(n_strobe >= 20), W'(1));
    check("t4_xfers", W'(n_xfer), W'(n_strobe));

    // Fixed pattern, abort after two beats of a 10-beat burst
    reset_counters(); rdy = 1'b1;
    start(2'b00, 8'd10, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin @(negedge clk); #1; found = (n_strobe >= 2); end
    @(posedge clk); #1;
    en = 1'b0;
    run_until_done(100, 0, 100, "t5");
    check("t5_strobes", W'(n_strobe), W'(2));
    check("t5_xfers", W'(n_xfer), W'(2));
    check("t5_first_beat", xfer_log[0], {2{64'h3333_3333_3333_3333}});

    // Table-driven randomized bursts
    for (int v = 0; v < 8; v++) begin
      reset_counters();
      start(tbl[v].sel, tbl[v].cnt, 1'b0);
      run_until_done(tbl[v].rdy_pct, tbl[v].full_pct, 4000, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_strobes", v), W'(n_strobe), W'(tbl[v].exp_beats));
      check($sformatf("vec%0d_xfers", v), W'(n_xfer), W'(tbl[v].exp_beats));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
